instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage of the five-stage MIPS pipeline, directly upstream of instruction decode. It owns the program counter, drives a synchronous single-cycle-latency instruction BRAM, and produces the IF/ID pipeline register (instruction, PC+4, valid) that decode and the control unit consume. It honours load-use stalls from the hazard logic and branch redirects resolved in decode, inserting bubbles as required.

## Interface
- `PC_WIDTH`, 32: program counter width in bits.
- `IMEM_ADDR_WIDTH`, 8: instruction BRAM word-address width. Depth is 2^IMEM_ADDR_WIDTH words.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset. Word aligned.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `stall`  in  1: hazard unit holds IF and IF/ID.
- `branch_taken`  in  1: branch resolved taken in decode this cycle.
- `branch_target`  in  PC_WIDTH: redirect address, word aligned.
- `imem_en`  out  1: BRAM read enable.
- `imem_addr`  out  IMEM_ADDR_WIDTH: BRAM word address, equal to `pc[IMEM_ADDR_WIDTH+1:2]`.
- `imem_data`  in  32: BRAM read data, valid the cycle after an enabled read.
- `if_id_instr`  out  32: registered instruction for decode.
- `if_id_pc_plus4`  out  PC_WIDTH: registered address of that instruction plus 4.
- `if_id_valid`  out  1: registered; 0 marks a bubble.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `pc_inflight`: address whose data is on `imem_data`.
  - `inflight_valid`.
  - The IF/ID triple.
- FSM states:
  - **BOOT**: the cycle after reset release. A fetch is issued and no IF/ID update occurs. Always goes to RUN.
  - **RUN**: normal operation. Goes to REDIRECT on `branch_taken && !stall`.
  - **REDIRECT**: the target fetch is issued and the in-flight word is discarded. Goes to RUN. If `branch_taken && !stall` arrives again here, it stays in REDIRECT with the new target.
- Reset values, applied asynchronously:
  - `pc` = RESET_PC, `pc_inflight` = RESET_PC, `inflight_valid` = 0.
  - `if_id_instr` = 32'h0000_0000 (NOP), `if_id_pc_plus4` = 0, `if_id_valid` = 0.
  - State = BOOT.
  - `imem_en` is 0 while `reset` is high.
- Normal advance (`!stall && !branch_taken`):
  - `pc <= pc + 4`.
  - `pc_inflight <= pc`, `inflight_valid <= 1`.
  - IF/ID loads `imem_data`, `pc_inflight + 4`, and `inflight_valid`.
- Stall:
  - `imem_en` = 0, so the BRAM output holds.
  - `pc`, in-flight registers, IF/ID and state are all unchanged.
  - Stall has priority: `branch_taken` is ignored while `stall` = 1.
- Branch taken (`branch_taken && !stall`):
  - `pc <= branch_target + 4`.
  - `imem_addr` is driven from `branch_target` this cycle (combinational mux), so the target fetch issues immediately.
  - `pc_inflight <= branch_target`, `inflight_valid <= 1`.
  - IF/ID loads NOP with `if_id_valid` = 0. The word on `imem_data` is the sequential successor and is killed.
  - There is no delay slot. Penalty is 1 bubble.
- Bubbles always carry instruction NOP with valid = 0. Decode must gate writes on `if_id_valid`.
- Arithmetic:
  - PC adds are modulo 2^PC_WIDTH.
  - `imem_addr` wraps modulo BRAM depth; no fault is raised.
  - Bits [1:0] of `pc` are always 0. Bits [1:0] of `branch_target` are ignored (forced to 0).

## Timing
- `imem_en` is 1 in every cycle where `reset` = 0 and `stall` = 0.
- Reset release at edge E0:
  - BOOT fetches RESET_PC between E0 and E1.
  - First valid IF/ID (instr @ RESET_PC, pc_plus4 = RESET_PC+4) appears after E2.
- Throughput: one instruction per unstalled cycle.
- Fetch-to-IF/ID latency: 2 edges.
- Branch asserted in the cycle between En and En+1:
  - After En+1: IF/ID is a bubble.
  - After En+2: IF/ID holds the target instruction.
- Reset mid-operation forces all outputs to reset values immediately and restarts at BOOT. Any in-flight data is discarded.

## Structure
- Shared package `pipeline_pkg` holds:
  - `NOP_INSTR` = 32'h0.
  - `PC_STEP` = 4.
  - The fetch FSM state encoding (BOOT, RUN, REDIRECT).
  - The IF/ID field widths, reused by decode.
- One sub-module `pc_reg`: PC register with asynchronous reset, load enable and next-PC mux (sequential / target). It is instantiated once.
- IF/ID register and FSM live in the top of `instruction_fetch`.

## Test plan
- **Reset and boot:** RESET_PC = 0, BRAM word i = 32'h1000_0000+i, reset released. Required: `if_id_valid` 0 for 2 cycles, then instructions 0x10000000, 0x10000001, 0x10000002 with `pc_plus4` 4, 8, 12 on consecutive cycles.
- **Stall hold:** assert `stall` 3 cycles while IF/ID = 0x10000005. Required: `if_id_instr`, `pc_plus4` (24) and `imem_addr` frozen and `imem_en` = 0. After release, next = 0x10000006 with no skipped or duplicated word.
- **Branch redirect:** `branch_taken` with target 0x40 while IF/ID holds word 3. Required: next cycle bubble (valid 0, instr 0), then word 16 (0x10000010) with pc_plus4 0x44, then word 17.
- **Stall with branch:** `stall` = 1 and `branch_taken` = 1 for 2 cycles, then `stall` = 0 with `branch_taken` = 1. Required: no redirect during stall; redirect occurs exactly once after release.
- **Back-to-back branches:** taken to 0x80, then on the next cycle taken to 0x100. Required: two bubbles, then word 64 (0x10000040). Word 32 is never valid.
- **Wrap and mid-run reset:**
  - IMEM_ADDR_WIDTH = 4, run 20 instructions. Required: `imem_addr` wraps 15→0 while `pc` continues to 0x40.
  - Reset asserted mid-cycle. Required: outputs reset asynchronously before the next edge and the boot sequence repeats.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, NOP word, PC step and
// IF/ID field widths reused by decode.
package pipeline_pkg;

    localparam int INSTR_WIDTH       = 32;
    localparam int IF_ID_VALID_WIDTH = 1;
    localparam int PC_STEP           = 4;

    typedef logic [INSTR_WIDTH-1:0] instr_t;

    localparam instr_t NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } fetch_state_t;

    // A slot that carries no instruction always presents the NOP encoding.
    function automatic instr_t bubble_or(input logic valid, input instr_t instr);
        return valid ? instr : NOP_INSTR;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: hazard/branch controls in, BRAM port, and the IF/ID
// register seen by decode.
interface instruction_fetch_if #(
    parameter int PC_WIDTH        = 32,
    parameter int IMEM_ADDR_WIDTH = 8
);
    import pipeline_pkg::*;

    logic                       stall;
    logic                       branch_taken;
    logic [PC_WIDTH-1:0]        branch_target;
    logic                       imem_en;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
    instr_t                     imem_data;
    instr_t                     if_id_instr;
    logic [PC_WIDTH-1:0]        if_id_pc_plus4;
    logic                       if_id_valid;

    modport master (
        input  stall, branch_taken, branch_target, imem_data,
        output imem_en, imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_data,
        input  imem_en, imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter with asynchronous reset, load enable and a sequential /
// branch-target mux; fetch_addr is the address issued to the BRAM this cycle.
module pc_reg
    import pipeline_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                sel_target,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] fetch_addr
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);

    logic [PC_WIDTH-1:0] pc;

    // Target low bits are dropped so pc stays word aligned.
    always_comb fetch_addr = sel_target ? (target & ALIGN_MASK) : pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC & ALIGN_MASK;
        end else if (load) begin
            pc <= fetch_addr + STEP;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage: PC, BRAM request, in-flight tracking and the
// IF/ID register, with load-use stalls and one-bubble branch redirects.
module instruction_fetch
    import pipeline_pkg::*;
#(
    parameter int                  PC_WIDTH        = 32,
    parameter int                  IMEM_ADDR_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC        = '0
) (
    input logic                 clk,
    input logic                 reset,
    instruction_fetch_if.master bus
);

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    fetch_state_t        state;
    logic                advance;
    logic                redirect;
    logic [PC_WIDTH-1:0] fetch_addr;
    logic [PC_WIDTH-1:0] pc_inflight;
    logic                inflight_valid;
    instr_t              if_id_instr;
    logic [PC_WIDTH-1:0] if_id_pc_plus4;
    logic                if_id_valid;

    // Stall outranks branch: a held stage cannot take a redirect.
    assign advance  = !bus.stall;
    assign redirect = bus.branch_taken && !bus.stall;

    pc_reg #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (advance),
        .sel_target (redirect),
        .target     (bus.branch_target),
        .fetch_addr (fetch_addr)
    );

    // BRAM port; holding imem_en low keeps the read data stable across a stall.
    assign bus.imem_en   = !reset && !bus.stall;
    assign bus.imem_addr = fetch_addr[IMEM_ADDR_WIDTH+1:2];

    assign bus.if_id_instr    = if_id_instr;
    assign bus.if_id_pc_plus4 = if_id_pc_plus4;
    assign bus.if_id_valid    = if_id_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= BOOT;
            pc_inflight    <= RESET_PC;
            inflight_valid <= 1'b0;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else if (advance) begin
            pc_inflight    <= fetch_addr;
            inflight_valid <= 1'b1;
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN, REDIRECT: begin
                    state          <= redirect ? REDIRECT : RUN;
                    if_id_pc_plus4 <= pc_inflight + STEP;
                    // On a redirect the word arriving now is the sequential successor.
                    if (redirect) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
                    end else begin
                        if_id_instr <= bubble_or(inflight_valid, bus.imem_data);
                        if_id_valid <= inflight_valid;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand sequences for
// redirect, mid-cycle reset and address wrap, then random traffic.
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    always #5 clk = ~clk;

    instruction_fetch_if #(.PC_WIDTH(32), .IMEM_ADDR_WIDTH(8)) bus_a ();
    instruction_fetch_if #(.PC_WIDTH(32), .IMEM_ADDR_WIDTH(4)) bus_b ();

    instruction_fetch #(.PC_WIDTH(32), .IMEM_ADDR_WIDTH(8), .RESET_PC(32'h0)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a)
    );

    instruction_fetch #(.PC_WIDTH(32), .IMEM_ADDR_WIDTH(4), .RESET_PC(32'h0)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b)
    );

    // Synchronous BRAMs whose word i holds 0x10000000 + i.
    always @(posedge clk) begin
        if (bus_a.imem_en) bus_a.imem_data <= 32'h1000_0000 + 32'(bus_a.imem_addr);
    end
    always @(posedge clk) begin
        if (bus_b.imem_en) bus_b.imem_data <= 32'h1000_0000 + 32'(bus_b.imem_addr);
    end

    typedef struct {
        logic        s;
        logic        b;
        logic [31:0] t;
        logic        en;
        logic [7:0]  addr;
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc4;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // word < 0 marks a bubble
    task automatic add(input int s, input int b, input int t, input int en,
                       input int addr, input int word, input int pc4);
        vec_t r;
        r.s     = s[0];
        r.b     = b[0];
        r.t     = t;
        r.en    = en[0];
        r.addr  = addr[7:0];
        r.v     = (word >= 0);
        r.instr = (word >= 0) ? 32'h1000_0000 + word : 32'h0;
        r.pc4   = pc4;
        tbl.push_back(r);
    endtask

    task automatic apply_a(input logic s, input logic b, input logic [31:0] t);
        bus_a.stall         = s;
        bus_a.branch_taken  = b;
        bus_a.branch_target = t;
        #1;
    endtask

    task automatic check_ifid_a(input string tag, input logic v, input logic [31:0] instr,
                                input logic [31:0] pc4);
        check({tag, ".valid"}, 32'(bus_a.if_id_valid), 32'(v));
        check({tag, ".instr"}, bus_a.if_id_instr, v ? instr : 32'h0);
        if (v) check({tag, ".pc4"}, bus_a.if_id_pc_plus4, pc4);
    endtask

    // Leaves the bench just after a negedge with reset released.
    task automatic reset_dut_a();
        @(negedge clk);
        reset_a = 1'b1;
        apply_a(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset_a = 1'b0;
    endtask

    logic [31:0] deliver;
    logic [31:0] exp_fetch;
    logic [31:0] exp_i;
    logic [31:0] exp_p;
    logic        exp_v;
    logic        boot;
    logic        rs;
    logic        rb;
    logic [31:0] rt;

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        bus_a.stall = 1'b0; bus_a.branch_taken = 1'b0; bus_a.branch_target = '0;
        bus_b.stall = 1'b0; bus_b.branch_taken = 1'b0; bus_b.branch_target = '0;

        add(0,0,0,     1,0,   -1,0);
        add(0,0,0,     1,1,    0,4);
        add(0,0,0,     1,2,    1,8);
        add(0,0,0,     1,3,    2,12);
        add(0,0,0,     1,4,    3,16);
        add(0,0,0,     1,5,    4,20);
        add(0,0,0,     1,6,    5,24);
        add(1,0,0,     0,7,    5,24);
        add(1,0,0,     0,7,    5,24);
        add(1,0,0,     0,7,    5,24);
        add(0,0,0,     1,7,    6,28);
        add(0,0,0,     1,8,    7,32);
        add(1,1,'h80,  0,9,    7,32);
        add(1,1,'h80,  0,9,    7,32);
        add(0,1,'h80,  1,32,  -1,0);
        add(0,0,0,     1,33,  32,'h84);
        add(0,0,0,     1,34,  33,'h88);
        add(0,1,'h80,  1,32,  -1,0);
        add(0,1,'h100, 1,64,  -1,0);
        add(0,0,0,     1,65,  64,'h104);
        add(0,0,0,     1,66,  65,'h108);
        add(0,1,'h1F3, 1,124, -1,0);
        add(0,0,0,     1,125,124,'h1F4);
        add(0,1,'h3FC, 1,255, -1,0);
        add(0,0,0,     1,0,  255,'h400);
        add(0,0,0,     1,1,    0,'h404);

        // Reset state
        @(negedge clk);
        check("rst.valid", 32'(bus_a.if_id_valid), 32'h0);
        check("rst.instr", bus_a.if_id_instr, 32'h0);
        check("rst.pc4", bus_a.if_id_pc_plus4, 32'h0);
        check("rst.en", 32'(bus_a.imem_en), 32'h0);
        reset_a = 1'b0;

        // Vector table
        for (int i = 0; i < tbl.size(); i++) begin
            apply_a(tbl[i].s, tbl[i].b, tbl[i].t);
            check($sformatf("vec%0d.en", i), 32'(bus_a.imem_en), 32'(tbl[i].en));
            check($sformatf("vec%0d.addr", i), 32'(bus_a.imem_addr), 32'(tbl[i].addr));
            @(posedge clk); #1;
            check_ifid_a($sformatf("vec%0d", i), tbl[i].v, tbl[i].instr, tbl[i].pc4);
            @(negedge clk);
        end

        // Redirect while IF/ID holds word 3
        reset_dut_a();
        for (int i = 0; i < 5; i++) begin
            apply_a(1'b0, 1'b0, 32'h0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        check_ifid_a("br.pre", 1'b1, 32'h1000_0003, 32'd16);
        apply_a(1'b0, 1'b1, 32'h40);
        @(posedge clk); #1;
        check_ifid_a("br.bubble", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        apply_a(1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        check_ifid_a("br.tgt", 1'b1, 32'h1000_0010, 32'h44);
        @(negedge clk);
        apply_a(1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        check_ifid_a("br.next", 1'b1, 32'h1000_0011, 32'h48);

        // Reset asserted mid-cycle acts before the next edge
        #2 reset_a = 1'b1;
        #1;
        check("midrst.valid", 32'(bus_a.if_id_valid), 32'h0);
        check("midrst.instr", bus_a.if_id_instr, 32'h0);
        check("midrst.pc4", bus_a.if_id_pc_plus4, 32'h0);
        check("midrst.en", 32'(bus_a.imem_en), 32'h0);
        @(negedge clk);
        reset_a = 1'b0;
        apply_a(1'b0, 1'b0, 32'h0);
        check("reboot.addr", 32'(bus_a.imem_addr), 32'h0);
        @(posedge clk); #1;
        check_ifid_a("reboot.1", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        check_ifid_a("reboot.2", 1'b1, 32'h1000_0000, 32'd4);
        @(negedge clk);

        // Address wrap on a 16-word BRAM while the PC keeps counting
        reset_b = 1'b0;
        for (int k = 0; k < 22; k++) begin
            #1;
            check($sformatf("wrap%0d.addr", k), 32'(bus_b.imem_addr), 32'(k % 16));
            @(posedge clk); #1;
            if (k == 0) begin
                check("wrap0.valid", 32'(bus_b.if_id_valid), 32'h0);
            end else begin
                check($sformatf("wrap%0d.instr", k), bus_b.if_id_instr, 32'h1000_0000 + 32'((k - 1) % 16));
                check($sformatf("wrap%0d.pc4", k), bus_b.if_id_pc_plus4, 32'(4 * k));
            end
            @(negedge clk);
        end

        // Random traffic against the delivery-order model
        reset_dut_a();
        deliver = 32'h0;
        boot    = 1'b1;
        exp_v   = 1'b0;
        exp_i   = 32'h0;
        exp_p   = 32'h0;
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(0, 3) == 0);
            rb = !boot && ($urandom_range(0, 4) == 0);
            rt = $urandom;
            apply_a(rs, rb, rt);
            if (!rs && rb) exp_fetch = rt & ~32'h3;
            else exp_fetch = boot ? deliver : deliver + 32'd4;
            check($sformatf("rnd%0d.en", i), 32'(bus_a.imem_en), 32'(!rs));
            check($sformatf("rnd%0d.addr", i), 32'(bus_a.imem_addr), 32'(exp_fetch[9:2]));
            @(posedge clk); #1;
            if (!rs) begin
                if (boot) begin
                    boot = 1'b0;
                end else if (rb) begin
                    exp_v   = 1'b0;
                    deliver = rt & ~32'h3;
                end else begin
                    exp_v   = 1'b1;
                    exp_i   = 32'h1000_0000 + 32'(deliver[9:2]);
                    exp_p   = deliver + 32'd4;
                    deliver = deliver + 32'd4;
                end
            end
            check_ifid_a($sformatf("rnd%0d", i), exp_v, exp_i, exp_p);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
